// File: rtl/plic_gateway_arbiter.sv
// PLIC interrupt core: input synchronisers, per-source edge/level gateways
// with pending/in-service tracking, and a priority arbiter that drives the
// registered claim ID and the external interrupt request to the hart.
module plic_gateway_arbiter #(
  parameter int NSRC        = 15,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        irq_src,
  input  logic [NSRC-1:0]        el,
  input  logic [NSRC-1:0]        ie,
  input  logic [NSRC*PRIO_W-1:0] pw,
  input  logic [PRIO_W-1:0]      th,
  input  logic                   claim,
  input  logic                   complete,
  input  logic [3:0]             complete_id,
  output logic [3:0]             id,
  output logic                   eip,
  output logic [NSRC-1:0]        pending,
  output logic [NSRC-1:0]        in_service
);

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] edge_q;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] claim_hit;
  logic [NSRC-1:0] complete_hit;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] serv_nxt;
  logic [NSRC-1:0] eq_nxt;
  logic [3:0]      win_id;
  logic            win_found;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;

  // Synchroniser chain and edge-history flop for every source line
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s;
    end
  end

  // Decode claim (against the registered winner) and complete into one-hot
  // per-source strobes; a strobe only fires when the target is in the right state
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (claim && (id != 4'd0) && (id == 4'(k + 1)) && pending[k])
        claim_hit[k] = 1'b1;
      if (complete && (complete_id == 4'(k + 1)) && in_service[k])
        complete_hit[k] = 1'b1;
    end
  end

  // Gateway next state: IDLE = 00, PEND = pending, SERV = in_service
  always_comb begin
    pend_nxt = pending;
    serv_nxt = in_service;
    eq_nxt   = edge_q;
    for (int k = 0; k < NSRC; k++) begin
      if (el[k]) begin
        if (!pending[k] && !in_service[k]) begin
          if (rise[k]) pend_nxt[k] = 1'b1;
        end else if (pending[k]) begin
          // Later rises merge into the pending request; a rise coinciding
          // with the claim is queued behind it
          if (claim_hit[k]) begin
            pend_nxt[k] = 1'b0;
            serv_nxt[k] = 1'b1;
            eq_nxt[k]   = rise[k];
          end
        end else begin
          if (complete_hit[k]) begin
            serv_nxt[k] = 1'b0;
            pend_nxt[k] = edge_q[k] | rise[k];
            eq_nxt[k]   = 1'b0;
          end else begin
            eq_nxt[k] = edge_q[k] | rise[k];
          end
        end
      end else begin
        eq_nxt[k] = 1'b0;
        if (!pending[k] && !in_service[k]) begin
          if (s[k]) pend_nxt[k] = 1'b1;
        end else if (pending[k]) begin
          // Claim takes precedence over a same-cycle deassertion
          if (claim_hit[k]) begin
            pend_nxt[k] = 1'b0;
            serv_nxt[k] = 1'b1;
          end else if (!s[k]) begin
            pend_nxt[k] = 1'b0;
          end
        end else begin
          if (complete_hit[k]) serv_nxt[k] = 1'b0;
        end
      end
    end
  end

  // Arbiter: highest priority above threshold wins, lowest index on ties.
  // The source being claimed this cycle is masked so id never repeats it.
  always_comb begin
    logic [PRIO_W-1:0] best_prio;
    logic [PRIO_W-1:0] prio;
    win_id    = 4'd0;
    win_found = 1'b0;
    best_prio = '0;
    for (int k = 0; k < NSRC; k++) begin
      prio = pw[k*PRIO_W +: PRIO_W];
      if (pending[k] && ie[k] && !claim_hit[k] && (prio > th) &&
          (!win_found || (prio > best_prio))) begin
        win_found = 1'b1;
        best_prio = prio;
        win_id    = 4'(k + 1);
      end
    end
  end

  // Gateway state and registered arbitration result
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      in_service <= '0;
      edge_q     <= '0;
      id         <= 4'd0;
      eip        <= 1'b0;
    end else begin
      pending    <= pend_nxt;
      in_service <= serv_nxt;
      edge_q     <= eq_nxt;
      id         <= win_id;
      eip        <= win_found;
    end
  end

endmodule

// File: tb/tb_plic_gateway_arbiter.sv
// Directed bench for plic_gateway_arbiter: latency, arbitration, edge queue,
// level re-pend, ignored accesses and mid-service reset.
module tb_plic_gateway_arbiter;

  localparam int N  = 15;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    irq_src;
  logic [N-1:0]    el;
  logic [N-1:0]    ie;
  logic [N*PW-1:0] pw;
  logic [PW-1:0]   th;
  logic            claim;
  logic            complete;
  logic [3:0]      complete_id;
  logic [3:0]      id;
  logic            eip;
  logic [N-1:0]    pending;
  logic [N-1:0]    in_service;

  int total = 0;
  int bad   = 0;

  plic_gateway_arbiter #(.NSRC(N), .PRIO_W(PW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .el(el), .ie(ie), .pw(pw),
    .th(th), .claim(claim), .complete(complete), .complete_id(complete_id),
    .id(id), .eip(eip), .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int k, input logic [PW-1:0] p);
    pw[k*PW +: PW] = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_src = '0; el = '0; ie = '0; pw = '0; th = '0;
    claim = 1'b0; complete = 1'b0; complete_id = 4'd0;
    step(); step();
    total++; if (pending !== 15'h0) begin bad++; $display("FAIL rst_pending got=%h want=0", pending); end
    total++; if (in_service !== 15'h0) begin bad++; $display("FAIL rst_in_service got=%h want=0", in_service); end
    total++; if (id !== 4'd0) begin bad++; $display("FAIL rst_id got=%0d want=0", id); end
    total++; if (eip !== 1'b0) begin bad++; $display("FAIL rst_eip got=%b want=0", eip); end
    rst = 1'b0;
    step();
    total++; if (pending !== 15'h0) begin bad++; $display("FAIL rst_first_cycle got=%h want=0", pending); end
  endtask

  task automatic test_latency();
    el = '0; el[2] = 1'b1; ie = '0; ie[2] = 1'b1; pw = '0; set_prio(2, 3); th = 0;
    irq_src[2] = 1'b1;
    step();
    total++; if (pending[2] !== 1'b0) begin bad++; $display("FAIL lat_e1_pend got=%b want=0", pending[2]); end
    step();
    total++; if (pending[2] !== 1'b0) begin bad++; $display("FAIL lat_e2_pend got=%b want=0", pending[2]); end
    step();
    total++; if (pending[2] !== 1'b1) begin bad++; $display("FAIL lat_e3_pend got=%b want=1", pending[2]); end
    total++; if (id !== 4'd0) begin bad++; $display("FAIL lat_e3_id got=%0d want=0", id); end
    step();
    total++; if (id !== 4'd3) begin bad++; $display("FAIL lat_e4_id got=%0d want=3", id); end
    total++; if (eip !== 1'b1) begin bad++; $display("FAIL lat_e4_eip got=%b want=1", eip); end
    claim = 1'b1; step(); claim = 1'b0;
    total++; if (in_service !== 15'h0004) begin bad++; $display("FAIL lat_claim_serv got=%h want=0004", in_service); end
    total++; if (pending !== 15'h0) begin bad++; $display("FAIL lat_claim_pend got=%h want=0", pending); end
    total++; if (id !== 4'd0 || eip !== 1'b0) begin bad++; $display("FAIL lat_claim_id got=%0d/%b want=0/0", id, eip); end
    complete_id = 4'd3; complete = 1'b1; step(); complete = 1'b0;
    total++; if (in_service !== 15'h0 || pending !== 15'h0) begin bad++; $display("FAIL lat_complete got=%h/%h want=0/0", pending, in_service); end
    irq_src[2] = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_tie();
    el = '0; ie = '0; ie[1] = 1'b1; ie[4] = 1'b1; pw = '0;
    set_prio(1, 5); set_prio(4, 5); th = 2;
    irq_src[1] = 1'b1; irq_src[4] = 1'b1;
    repeat (4) step();
    total++; if (id !== 4'd2) begin bad++; $display("FAIL tie_id got=%0d want=2", id); end
    total++; if (eip !== 1'b1) begin bad++; $display("FAIL tie_eip got=%b want=1", eip); end
    set_prio(4, 6); step();
    total++; if (id !== 4'd5) begin bad++; $display("FAIL prio_id got=%0d want=5", id); end
    th = 6; step();
    total++; if (id !== 4'd0 || eip !== 1'b0) begin bad++; $display("FAIL th_id got=%0d/%b want=0/0", id, eip); end
    total++; if (pending !== 15'h0012) begin bad++; $display("FAIL th_pend got=%h want=0012", pending); end
    irq_src[1] = 1'b0; irq_src[4] = 1'b0;
    repeat (4) step();
    total++; if (pending !== 15'h0) begin bad++; $display("FAIL level_withdraw got=%h want=0", pending); end
    th = 0;
  endtask

  task automatic test_edge_queue();
    el = '0; el[0] = 1'b1; ie = '0; ie[0] = 1'b1; pw = '0; set_prio(0, 1); th = 0;
    irq_src[0] = 1'b1;
    repeat (4) step();
    total++; if (id !== 4'd1) begin bad++; $display("FAIL eq_id got=%0d want=1", id); end
    claim = 1'b1; step(); claim = 1'b0;
    total++; if (in_service[0] !== 1'b1 || pending[0] !== 1'b0 || id !== 4'd0) begin
      bad++; $display("FAIL eq_claim got=s%b p%b id%0d want=s1 p0 id0", in_service[0], pending[0], id); end
    irq_src[0] = 1'b0; step();
    irq_src[0] = 1'b1; step();
    irq_src[0] = 1'b0; step();
    irq_src[0] = 1'b1; step();
    irq_src[0] = 1'b0;
    repeat (4) step();
    total++; if (in_service[0] !== 1'b1 || pending[0] !== 1'b0) begin
      bad++; $display("FAIL eq_serv_hold got=s%b p%b want=s1 p0", in_service[0], pending[0]); end
    complete_id = 4'd1; complete = 1'b1; step(); complete = 1'b0;
    total++; if (pending[0] !== 1'b1 || in_service[0] !== 1'b0) begin
      bad++; $display("FAIL eq_requeue got=p%b s%b want=p1 s0", pending[0], in_service[0]); end
    step();
    total++; if (id !== 4'd1 || eip !== 1'b1) begin bad++; $display("FAIL eq_reid got=%0d/%b want=1/1", id, eip); end
    claim = 1'b1; step(); claim = 1'b0;
    total++; if (in_service[0] !== 1'b1) begin bad++; $display("FAIL eq_claim2 got=%b want=1", in_service[0]); end
    complete = 1'b1; step(); complete = 1'b0;
    total++; if (pending[0] !== 1'b0 || in_service[0] !== 1'b0) begin
      bad++; $display("FAIL eq_idle got=p%b s%b want=p0 s0", pending[0], in_service[0]); end
    step();
    total++; if (id !== 4'd0 || eip !== 1'b0) begin bad++; $display("FAIL eq_final_id got=%0d/%b want=0/0", id, eip); end
  endtask

  task automatic test_level_repend();
    el = '0; ie = '0; ie[7] = 1'b1; pw = '0; set_prio(7, 2); th = 0;
    irq_src[7] = 1'b1;
    repeat (4) step();
    total++; if (id !== 4'd8) begin bad++; $display("FAIL lv_id got=%0d want=8", id); end
    claim = 1'b1; step(); claim = 1'b0;
    total++; if (in_service[7] !== 1'b1 || pending[7] !== 1'b0) begin
      bad++; $display("FAIL lv_claim got=s%b p%b want=s1 p0", in_service[7], pending[7]); end
    repeat (2) step();
    total++; if (in_service[7] !== 1'b1 || pending[7] !== 1'b0) begin
      bad++; $display("FAIL lv_serv_ignore got=s%b p%b want=s1 p0", in_service[7], pending[7]); end
    complete_id = 4'd8; complete = 1'b1; step(); complete = 1'b0;
    total++; if (in_service[7] !== 1'b0 || pending[7] !== 1'b0) begin
      bad++; $display("FAIL lv_complete got=s%b p%b want=s0 p0", in_service[7], pending[7]); end
    step();
    total++; if (pending[7] !== 1'b1) begin bad++; $display("FAIL lv_repend got=%b want=1", pending[7]); end
    step();
    total++; if (id !== 4'd8) begin bad++; $display("FAIL lv_reid got=%0d want=8", id); end
    claim = 1'b1; step(); claim = 1'b0;
    total++; if (in_service[7] !== 1'b1) begin bad++; $display("FAIL lv_claim2 got=%b want=1", in_service[7]); end
    irq_src[7] = 1'b0;
    repeat (3) step();
    complete = 1'b1; step(); complete = 1'b0;
    total++; if (in_service[7] !== 1'b0 || pending[7] !== 1'b0) begin
      bad++; $display("FAIL lv_low_complete got=s%b p%b want=s0 p0", in_service[7], pending[7]); end
    repeat (2) step();
    total++; if (pending[7] !== 1'b0 || id !== 4'd0) begin
      bad++; $display("FAIL lv_stay_idle got=p%b id%0d want=p0 id0", pending[7], id); end
  endtask

  task automatic test_ignored();
    el = '0; el[6] = 1'b1; ie = '0; ie[6] = 1'b1; pw = '0; set_prio(6, 4); th = 0;
    irq_src[6] = 1'b1;
    repeat (4) step();
    total++; if (id !== 4'd7) begin bad++; $display("FAIL ig_id got=%0d want=7", id); end
    complete = 1'b1;
    complete_id = 4'd0; step();
    total++; if (pending !== 15'h0040 || in_service !== 15'h0) begin
      bad++; $display("FAIL ig_cid0 got=%h/%h want=0040/0000", pending, in_service); end
    complete_id = 4'd15; step();
    total++; if (pending !== 15'h0040 || in_service !== 15'h0) begin
      bad++; $display("FAIL ig_cid15 got=%h/%h want=0040/0000", pending, in_service); end
    complete_id = 4'd7; step();
    complete = 1'b0;
    total++; if (pending !== 15'h0040 || in_service !== 15'h0) begin
      bad++; $display("FAIL ig_cid_pend got=%h/%h want=0040/0000", pending, in_service); end
    total++; if (id !== 4'd7) begin bad++; $display("FAIL ig_id_hold got=%0d want=7", id); end
    th = 7; step();
    total++; if (id !== 4'd0) begin bad++; $display("FAIL ig_th7_id got=%0d want=0", id); end
    claim = 1'b1; step(); claim = 1'b0;
    total++; if (pending !== 15'h0040 || in_service !== 15'h0) begin
      bad++; $display("FAIL ig_claim_id0 got=%h/%h want=0040/0000", pending, in_service); end
    th = 0; step();
    total++; if (id !== 4'd7) begin bad++; $display("FAIL ig_th0_id got=%0d want=7", id); end
    claim = 1'b1; step(); claim = 1'b0;
    total++; if (in_service !== 15'h0040) begin bad++; $display("FAIL ig_claim got=%h want=0040", in_service); end
    complete_id = 4'd7; complete = 1'b1; step(); complete = 1'b0;
    total++; if (in_service !== 15'h0 || pending !== 15'h0) begin
      bad++; $display("FAIL ig_done got=%h/%h want=0/0", pending, in_service); end
    irq_src[6] = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    el = '0; el[3] = 1'b1; ie = '0; ie[3] = 1'b1; ie[5] = 1'b1; ie[9] = 1'b1;
    pw = '0; set_prio(3, 5); set_prio(5, 1); set_prio(9, 6); th = 0;
    irq_src[3] = 1'b1; irq_src[5] = 1'b1; irq_src[9] = 1'b1;
    repeat (4) step();
    total++; if (id !== 4'd10) begin bad++; $display("FAIL rm_id got=%0d want=10", id); end
    claim = 1'b1; step();
    total++; if (in_service !== 15'h0200 || id !== 4'd4) begin
      bad++; $display("FAIL rm_claim9 got=%h id%0d want=0200 id4", in_service, id); end
    step(); claim = 1'b0;
    total++; if (in_service !== 15'h0208 || pending !== 15'h0020 || id !== 4'd6) begin
      bad++; $display("FAIL rm_claim3 got=s%h p%h id%0d want=s0208 p0020 id6", in_service, pending, id); end
    rst = 1'b1; irq_src[3] = 1'b0; irq_src[9] = 1'b0;
    step(); rst = 1'b0;
    total++; if (pending !== 15'h0 || in_service !== 15'h0 || id !== 4'd0 || eip !== 1'b0) begin
      bad++; $display("FAIL rm_reset got=p%h s%h id%0d eip%b want=0", pending, in_service, id, eip); end
    step();
    total++; if (pending !== 15'h0) begin bad++; $display("FAIL rm_e1 got=%h want=0", pending); end
    step();
    total++; if (pending !== 15'h0) begin bad++; $display("FAIL rm_e2 got=%h want=0", pending); end
    step();
    total++; if (pending !== 15'h0020) begin bad++; $display("FAIL rm_e3 got=%h want=0020", pending); end
    step();
    total++; if (id !== 4'd6 || eip !== 1'b1) begin bad++; $display("FAIL rm_e4 got=%0d/%b want=6/1", id, eip); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tie();
    test_edge_queue();
    test_level_repend();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
